logic_reduce_unit: RTL and testbench
====================================

LOGIC_REDUCE_UNIT -- requirements
Module: logic_reduce_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each lane and of the result (1..32).
REQ-002 SHALL have parameter NUM_IN, default 4, number of input lanes reduced per beat (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  lanes; lane k = bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_last  input  1  final beat of a frame.
REQ-009 SHALL have port op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
REQ-010 SHALL have port out_valid  output  1  result held in Y.
REQ-011 SHALL have port out_ready  input  1  downstream takes the result this cycle.
REQ-012 SHALL have port Y  output  WIDTH  registered frame result.
REQ-013 SHALL have port op_err  output  1  frame used a reserved op; qualified by out_valid.

Function
REQ-014 SHALL transfer an input beat only when in_valid && in_ready; the output result only when out_valid && out_ready.
REQ-015 SHALL reduce all lanes of an accepted beat bitwise with the base op: AND for 0/3, OR for 1/4, XOR for 2/5.
REQ-016 SHALL run FSM states IDLE (no frame open), ACC (frame open, partial result in accumulator), FULL (result in Y awaiting out_ready).
REQ-017 SHALL, in IDLE, on an accepted beat latch op, load the accumulator with that beat's reduction, and go to ACC if in_last=0, else FULL.
REQ-018 SHALL, in ACC, combine each accepted beat's reduction into the accumulator with the latched base op; op changes mid-frame are ignored.
REQ-019 SHALL, on the accepted in_last beat, load Y with the final accumulation, inverted for ops 3/4/5, and assert out_valid the next cycle (latency 1 cycle).
REQ-020 SHALL drive in_ready = (state != FULL) || out_ready, so that a new beat is accepted in the same cycle the held result is consumed.
REQ-021 SHALL, in FULL with out_ready=1, go to IDLE, ACC or FULL per REQ-017 if a beat is accepted the same cycle, else go to IDLE.
REQ-022 SHALL hold Y, op_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL treat reserved ops 6/7 as OR and set op_err=1 for that frame's result; op_err=0 otherwise.
REQ-024 SHALL NOT change state on in_valid=0 cycles; a frame may have idle gaps between beats.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state IDLE, accumulator 0, Y 0, out_valid 0 and op_err 0; rst overrides all other inputs.
REQ-026 SHALL discard a partial frame or an unconsumed result on reset; the first beat after reset opens a new frame.
REQ-027 SHALL drive in_ready 1 during and after reset (state IDLE).

Configuration
REQ-028 SHALL, with macro LOGIC_REDUCE_ACC_EN defined, implement multi-beat frames per REQ-017/018 using in_last.
REQ-029 SHALL, without LOGIC_REDUCE_ACC_EN, ignore in_last, treat every accepted beat as a one-beat frame, never enter ACC, and remove the accumulator.

Verification (WIDTH=8, NUM_IN=4, macro defined unless noted; lanes listed 0..3)
REQ-030 SHALL cover single-beat OR: lanes 01,02,04,80, op=1, last=1 -> next cycle out_valid=1, Y=0x87, op_err=0.
REQ-031 SHALL cover two-beat NAND: lanes FF,FF,F0,FF then FF,3C,FF,FF with last, op=3 on beat 1 and op=0 on beat 2 -> Y=0xCF one cycle after beat 2.
REQ-032 SHALL cover backpressure: result held with out_ready=0 for 3 cycles -> in_ready=0, Y unchanged; out_ready=1 with a pending beat -> result consumed and beat accepted in the same cycle.
REQ-033 SHALL cover reserved op: op=7, lanes 10,20,00,01, last=1 -> Y=0x31, op_err=1.
REQ-034 SHALL cover reset mid-frame: XOR beat lanes FF,00,00,00 (last=0), rst for one cycle, then lanes 0F,00,00,00 last, op=2 -> Y=0x0F.
REQ-035 SHALL cover macro undefined: two beats with last=0, op=1, lanes 01,00,00,00 then 02,00,00,00 -> two results, Y=0x01 then Y=0x02.

Source files
------------

// File: rtl/logic_reduce_unit.sv
// Frame-wise bitwise reduction of NUM_IN lanes with AND/OR/XOR (optionally inverted) and a one-deep result register.
// Multi-beat frames using in_last are built only when LOGIC_REDUCE_ACC_EN is defined; otherwise every beat is a frame.
module logic_reduce_unit #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        Y,
    output logic                    op_err
);

    typedef enum logic [1:0] {IDLE, ACC, FULL} state_t;
    typedef enum logic [1:0] {BASE_AND, BASE_OR, BASE_XOR} base_t;

    state_t state, state_next;

    function automatic base_t base_of(input logic [2:0] code);
        case (code)
            3'd0, 3'd3: return BASE_AND;
            3'd2, 3'd5: return BASE_XOR;
            default:    return BASE_OR;  // reserved codes 6/7 fold into OR
        endcase
    endfunction

    function automatic logic inv_of(input logic [2:0] code);
        return (code >= 3'd3) && (code <= 3'd5);
    endfunction

    function automatic logic err_of(input logic [2:0] code);
        return code[2] & code[1];
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input base_t base);
        case (base)
            BASE_AND: return a & b;
            BASE_XOR: return a ^ b;
            default:  return a | b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] reduce_lanes(input logic [NUM_IN*WIDTH-1:0] data,
                                                      input base_t base);
        logic [WIDTH-1:0] r;
        r = data[0 +: WIDTH];
        for (int k = 1; k < NUM_IN; k++) begin
            r = combine(r, data[k*WIDTH +: WIDTH], base);
        end
        return r;
    endfunction

    logic             accept;
    logic             last_beat;
    base_t            eff_base;
    logic             eff_inv;
    logic             eff_err;
    logic [WIDTH-1:0] beat_red;
    logic [WIDTH-1:0] acc_next;

    assign in_ready = (state != FULL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign beat_red = reduce_lanes(in_data, eff_base);

`ifdef LOGIC_REDUCE_ACC_EN
    logic [WIDTH-1:0] acc;
    base_t            base_q;
    logic             inv_q;
    logic             err_q;
    logic             frame_open;

    // Once a frame is open its op is frozen; later op values are ignored.
    assign frame_open = (state == ACC);
    assign eff_base   = frame_open ? base_q : base_of(op);
    assign eff_inv    = frame_open ? inv_q  : inv_of(op);
    assign eff_err    = frame_open ? err_q  : err_of(op);
    assign acc_next   = frame_open ? combine(acc, beat_red, base_q) : beat_red;
    assign last_beat  = in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            base_q <= BASE_OR;
            inv_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept && !in_last) begin
            acc <= acc_next;
            if (!frame_open) begin
                base_q <= base_of(op);
                inv_q  <= inv_of(op);
                err_q  <= err_of(op);
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = in_last;
    assign eff_base    = base_of(op);
    assign eff_inv     = inv_of(op);
    assign eff_err     = err_of(op);
    assign acc_next    = beat_red;
    assign last_beat   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = last_beat ? FULL : ACC;
        end else if ((state == FULL) && out_ready) begin
            state_next = IDLE;
        end
    end

    // Result register: loaded on the closing beat, cleared when consumed without a replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y         <= '0;
            out_valid <= 1'b0;
            op_err    <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                Y         <= eff_inv ? ~acc_next : acc_next;
                op_err    <= eff_err;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit (WIDTH=8, NUM_IN=4); multi-beat cases depend on LOGIC_REDUCE_ACC_EN.
module tb_logic_reduce_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Y;
    logic        op_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    logic_reduce_unit #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .op_err    (op_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        op       = o;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        op        = 3'd0;
        out_ready = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", Y, 8'h00);
        check("rst_op_err", op_err, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // Single-beat OR, then hold under backpressure
        drive(3'd1, {8'h80, 8'h04, 8'h02, 8'h01}, 1'b1);
        tick();
        in_valid = 1'b0;
        check("or_out_valid", out_valid, 1);
        check("or_y", Y, 8'h87);
        check("or_op_err", op_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_y_hold", Y, 8'h87);
        end

        // Release backpressure with a reserved-op beat waiting: consume and accept together
        drive(3'd7, {8'h01, 8'h00, 8'h20, 8'h10}, 1'b1);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("rsv_out_valid", out_valid, 1);
        check("rsv_y", Y, 8'h31);
        check("rsv_op_err", op_err, 1);
        tick();
        check("drain_out_valid", out_valid, 0);

        // Reset in the middle of an XOR frame
        drive(3'd2, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        drive(3'd2, {8'h00, 8'h00, 8'h00, 8'h0F}, 1'b1);
        tick();
        in_valid = 1'b0;
        check("xor_out_valid", out_valid, 1);
        check("xor_y", Y, 8'h0F);
        check("xor_op_err", op_err, 0);
        tick();
        check("xor_drain", out_valid, 0);

`ifdef LOGIC_REDUCE_ACC_EN
        // Two-beat NAND with an idle gap and a changed op on the second beat
        out_ready = 1'b0;
        drive(3'd3, {8'hFF, 8'hF0, 8'hFF, 8'hFF}, 1'b0);
        tick();
        in_valid = 1'b0;
        check("nand_b1_out_valid", out_valid, 0);
        tick();
        check("nand_gap_out_valid", out_valid, 0);
        drive(3'd0, {8'hFF, 8'hFF, 8'h3C, 8'hFF}, 1'b1);
        tick();
        in_valid = 1'b0;
        check("nand_out_valid", out_valid, 1);
        check("nand_y", Y, 8'hCF);
        check("nand_op_err", op_err, 0);
        out_ready = 1'b1;
        tick();
        check("nand_drain", out_valid, 0);
`else
        // in_last ignored: each beat is its own frame
        out_ready = 1'b1;
        drive(3'd1, {8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        tick();
        check("one_a_out_valid", out_valid, 1);
        check("one_a_y", Y, 8'h01);
        drive(3'd1, {8'h00, 8'h00, 8'h00, 8'h02}, 1'b0);
        tick();
        in_valid = 1'b0;
        check("one_b_out_valid", out_valid, 1);
        check("one_b_y", Y, 8'h02);
        tick();
        check("one_drain", out_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
